// File: rtl/rv32_ctrl_pkg.sv
// Shared control definitions for the RV32I buffer-internal core: run-sequencer
// states, system-instruction encodings and a saturating counter helper.
package rv32_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } run_state_e;

  localparam logic [31:0] ECALL_CODE  = 32'h0000_0073;
  localparam logic [31:0] EBREAK_CODE = 32'h0010_0073;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/imem_loader.sv
// Host-to-instruction-BRAM loader: valid/ready handshake, write index and the
// registered BRAM write port. Pulses finish during the final write cycle.
module imem_loader #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  output logic              finish,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata
);

  logic [ADDR_W:0] len_r;
  logic [ADDR_W:0] idx_r;
  logic            xfer_s;
  logic            last_s;

  // Transfer detect; the index is one bit wider than the address so a full
  // 2^ADDR_W load compares cleanly against len.
  always_comb begin
    xfer_s = ld_valid & ld_ready;
    last_s = ((idx_r + (ADDR_W+1)'(1)) == len_r);
  end

  // Accepted word is written to BRAM on the following cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_r      <= (ADDR_W+1)'(0);
      idx_r      <= (ADDR_W+1)'(0);
      ld_ready   <= 1'b0;
      finish     <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= ADDR_W'(0);
      imem_wdata <= DATA_W'(0);
    end else begin
      imem_we <= 1'b0;
      finish  <= 1'b0;
      if (start) begin
        len_r    <= len;
        idx_r    <= (ADDR_W+1)'(0);
        ld_ready <= 1'b1;
      end else if (xfer_s) begin
        imem_we    <= 1'b1;
        imem_addr  <= idx_r[ADDR_W-1:0];
        imem_wdata <= ld_data;
        idx_r      <= idx_r + (ADDR_W+1)'(1);
        if (last_s) begin
          ld_ready <= 1'b0;
          finish   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/core_run_sequencer.sv
// Run controller: loads a program into instruction BRAM, runs the core until
// ecall or timeout, drains in-flight ops and reports done with a cycle count.
module core_run_sequencer #(
  parameter int                ADDR_W     = 10,
  parameter int                DATA_W     = 32,
  parameter int                DRAIN_CYC  = 4,
  parameter logic [DATA_W-1:0] ECALL_CODE = DATA_W'(rv32_ctrl_pkg::ECALL_CODE)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_in,
  input  logic [ADDR_W:0]   load_len,
  input  logic [31:0]       timeout_lim,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              imem_sel,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              core_rst,
  output logic              core_en,
  input  logic [DATA_W-1:0] core_instr,
  input  logic              core_instr_vld,
  output logic              busy,
  output logic              done,
  output logic              timeout_err,
  output logic [31:0]       cycle_cnt
);
  import rv32_ctrl_pkg::*;

  localparam int DRAIN_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  run_state_e         state_r;
  run_state_e         state_nxt_s;
  logic [31:0]        timeout_lim_r;
  logic [DRAIN_W-1:0] drain_cnt_r;
  logic               ecall_s;
  logic               tmo_hit_s;
  logic               ld_start_s;
  logic               ld_finish_s;
  logic               nx_core_rst_s;
  logic               nx_core_en_s;
  logic               nx_imem_sel_s;
  logic               nx_busy_s;
  logic               nx_done_s;

  imem_loader #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_loader (
    .clk        (clk),
    .rst        (rst),
    .start      (ld_start_s),
    .len        (load_len),
    .finish     (ld_finish_s),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .ld_ready   (ld_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata)
  );

  // Run-end conditions and loader kick-off.
  always_comb begin
    ecall_s    = core_instr_vld & (core_instr == ECALL_CODE);
    tmo_hit_s  = (timeout_lim_r != 32'd0) && (cycle_cnt == (timeout_lim_r - 32'd1));
    ld_start_s = (state_r == IDLE) && start_in && (load_len != {(ADDR_W+1){1'b0}});
  end

  // Next-state logic; ecall takes priority over a coincident timeout.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_in) begin
          state_nxt_s = (load_len != {(ADDR_W+1){1'b0}}) ? LOAD : RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      LOAD: begin
        if (ld_finish_s) state_nxt_s = RUN;
        else             state_nxt_s = LOAD;
      end
      RUN: begin
        if (ecall_s)        state_nxt_s = DRAIN;
        else if (tmo_hit_s) state_nxt_s = DONE;
        else                state_nxt_s = RUN;
      end
      DRAIN: begin
        if (drain_cnt_r == DRAIN_W'(0)) state_nxt_s = DONE;
        else                            state_nxt_s = DRAIN;
      end
      DONE: begin
        if (!start_in) state_nxt_s = IDLE;
        else           state_nxt_s = DONE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Output decode from the next state so the registered outputs line up with state_r.
  always_comb begin
    nx_core_rst_s = 1'b1;
    nx_core_en_s  = 1'b0;
    nx_imem_sel_s = 1'b0;
    nx_busy_s     = 1'b0;
    nx_done_s     = 1'b0;
    case (state_nxt_s)
      IDLE: begin
        nx_core_rst_s = 1'b1;
      end
      LOAD: begin
        nx_imem_sel_s = 1'b1;
        nx_busy_s     = 1'b1;
      end
      RUN, DRAIN: begin
        nx_core_rst_s = 1'b0;
        nx_core_en_s  = 1'b1;
        nx_busy_s     = 1'b1;
      end
      DONE: begin
        nx_core_rst_s = 1'b0;
        nx_done_s     = 1'b1;
      end
      default: begin
        nx_core_rst_s = 1'b1;
      end
    endcase
  end

  // State and control-output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      core_rst <= 1'b1;
      core_en  <= 1'b0;
      imem_sel <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      core_rst <= nx_core_rst_s;
      core_en  <= nx_core_en_s;
      imem_sel <= nx_imem_sel_s;
      busy     <= nx_busy_s;
      done     <= nx_done_s;
    end
  end

  // Run bookkeeping: timeout latch, cycle counter, drain counter, timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      timeout_lim_r <= 32'd0;
      cycle_cnt     <= 32'd0;
      timeout_err   <= 1'b0;
      drain_cnt_r   <= DRAIN_W'(0);
    end else begin
      case (state_r)
        IDLE: begin
          if (start_in) begin
            timeout_lim_r <= timeout_lim;
            cycle_cnt     <= 32'd0;
            timeout_err   <= 1'b0;
          end
        end
        RUN: begin
          cycle_cnt <= sat_inc32(cycle_cnt);
          if (ecall_s) begin
            drain_cnt_r <= DRAIN_W'(DRAIN_CYC - 1);
          end else if (tmo_hit_s) begin
            timeout_err <= 1'b1;
          end
        end
        DRAIN: begin
          cycle_cnt   <= sat_inc32(cycle_cnt);
          drain_cnt_r <= drain_cnt_r - DRAIN_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_core_run_sequencer.sv
// Self-checking bench for core_run_sequencer: randomized program words, handshake
// gaps and instruction streams checked against run-outcome rules.
module tb_core_run_sequencer;

  localparam int          ADDR_W = 10;
  localparam int          DATA_W = 32;
  localparam int          DRAIN  = 4;
  localparam logic [31:0] ECALL  = 32'h0000_0073;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start_in = 1'b0;
  logic [ADDR_W:0]   load_len = '0;
  logic [31:0]       timeout_lim = '0;
  logic              ld_valid = 1'b0;
  logic [DATA_W-1:0] ld_data = '0;
  logic              ld_ready;
  logic              imem_sel;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_wdata;
  logic              core_rst;
  logic              core_en;
  logic [DATA_W-1:0] core_instr = '0;
  logic              core_instr_vld = 1'b0;
  logic              busy;
  logic              done;
  logic              timeout_err;
  logic [31:0]       cycle_cnt;

  int vectors = 0;
  int miscompares = 0;

  // monitor-owned observations
  int cyc = 0;
  logic [ADDR_W+DATA_W-1:0] wr_q[$];
  int xfers = 0;
  int en_cycles = 0;
  int en_rise_cyc = -1;
  int last_we_cyc = -1;
  int port_viol = 0;
  logic prev_en = 1'b0;

  logic [31:0] prog [0:1023];
  int last_cnt;

  core_run_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .start_in       (start_in),
    .load_len       (load_len),
    .timeout_lim    (timeout_lim),
    .ld_valid       (ld_valid),
    .ld_data        (ld_data),
    .ld_ready       (ld_ready),
    .imem_sel       (imem_sel),
    .imem_we        (imem_we),
    .imem_addr      (imem_addr),
    .imem_wdata     (imem_wdata),
    .core_rst       (core_rst),
    .core_en        (core_en),
    .core_instr     (core_instr),
    .core_instr_vld (core_instr_vld),
    .busy           (busy),
    .done           (done),
    .timeout_err    (timeout_err),
    .cycle_cnt      (cycle_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe the BRAM port, handshakes and core enable mid-cycle.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wr_q.push_back({imem_addr, imem_wdata});
      last_we_cyc = cyc;
    end
    if (ld_valid && (ld_ready === 1'b1)) xfers++;
    if (core_en === 1'b1) begin
      en_cycles++;
      if (prev_en !== 1'b1) en_rise_cyc = cyc;
    end
    prev_en = core_en;
    if ((imem_we === 1'b1) && (imem_sel !== 1'b1)) port_viol++;
    if ((ld_ready === 1'b1) && (imem_sel !== 1'b1 || core_rst !== 1'b1)) port_viol++;
    if ((core_en === 1'b1) && (imem_sel !== 1'b0 || core_rst !== 1'b0)) port_viol++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_gap();
    start_in = 1'b0;
    tick();
    tick();
  endtask

  // One complete run: load len words (vpct% valid density), ecall on RUN cycle e (0 = never).
  task automatic run_case(input int len, input int lim, input int e, input int vpct);
    int k, r, wbase, xbase, ebase, vbase, budget, bad, exp_cnt;
    bit hs, exp_to;
    logic [ADDR_W+DATA_W-1:0] expw;
    for (int i = 0; i < len; i++) prog[i] = $urandom;
    wbase = wr_q.size();
    xbase = xfers;
    ebase = en_cycles;
    vbase = port_viol;
    k = 0; r = 0; hs = 1'b0;
    load_len    = (ADDR_W+1)'(len);
    timeout_lim = lim;
    start_in    = 1'b1;
    budget = 4 * len + lim + e + 60;
    for (int c = 0; c < budget; c++) begin
      tick();
      if (hs) k++;
      if (done === 1'b1) break;
      if (core_en === 1'b1) r++;
      ld_valid = ($urandom_range(99) < vpct);
      ld_data  = (k < len) ? prog[k] : $urandom;
      hs = ld_valid && (ld_ready === 1'b1);
      if ((core_en === 1'b1) && (r == e)) begin
        core_instr     = ECALL;
        core_instr_vld = 1'b1;
      end else begin
        core_instr_vld = $urandom_range(1);
        core_instr     = core_instr_vld ? ($urandom | 32'h0000_0100) : ECALL;
      end
    end
    ld_valid = 1'b0;
    core_instr_vld = 1'b0;

    exp_to  = (lim != 0) && ((e == 0) || (e > lim));
    exp_cnt = exp_to ? lim : e + DRAIN;
    last_cnt = exp_cnt;
    chk("done", done, 1);
    chk("busy_in_done", busy, 0);
    chk("core_en_in_done", core_en, 0);
    chk("core_rst_in_done", core_rst, 0);
    chk("timeout_err", timeout_err, exp_to);
    chk("cycle_cnt", cycle_cnt, exp_cnt);
    chk("enabled_cycles", en_cycles - ebase, exp_cnt);
    chk("xfer_count", xfers - xbase, len);
    chk("write_count", wr_q.size() - wbase, len);
    bad = 0;
    for (int i = 0; i < len && (wbase + i) < wr_q.size(); i++) begin
      expw = {ADDR_W'(i), prog[i]};
      if (wr_q[wbase + i] !== expw) bad++;
    end
    chk("write_addr_data", bad, 0);
    chk("port_ownership", port_viol - vbase, 0);
    if (len > 0) chk("run_after_last_write", en_rise_cyc, last_we_cyc + 1);
  endtask

  initial begin
    int xbase, wb, nr, rl, rt, re;

    // reset state
    tick();
    tick();
    chk("rst_ld_ready", ld_ready, 0);
    chk("rst_imem_we", imem_we, 0);
    chk("rst_imem_addr", imem_addr, 0);
    chk("rst_imem_wdata", imem_wdata, 0);
    chk("rst_imem_sel", imem_sel, 0);
    chk("rst_core_rst", core_rst, 1);
    chk("rst_core_en", core_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_timeout_err", timeout_err, 0);
    chk("rst_cycle_cnt", cycle_cnt, 0);
    rst = 1'b0;
    tick();

    // basic: 4 words back-to-back, ecall on RUN cycle 10
    run_case(4, 0, 10, 100);
    idle_gap();
    // backpressure on a short load
    run_case(3, 0, 5, 40);
    idle_gap();
    // timeout with no ecall
    run_case(5, 20, 0, 70);
    // held start in DONE must not retrigger
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_done", done, 1);
      chk("hold_cnt", cycle_cnt, last_cnt);
    end
    start_in = 1'b0;
    tick();
    chk("back_to_idle_done", done, 0);
    chk("back_to_idle_core_rst", core_rst, 1);
    tick();
    // empty load goes straight to RUN
    run_case(0, 0, 3, 80);
    idle_gap();
    // ecall on the timeout cycle wins
    run_case(2, 8, 8, 90);
    idle_gap();
    // ecall one cycle too late: timeout
    run_case(2, 8, 9, 90);
    idle_gap();
    // timeout of one cycle and ecall on the first RUN cycle
    run_case(1, 1, 0, 100);
    idle_gap();
    run_case(0, 0, 1, 100);
    idle_gap();
    // full-size program
    run_case(1024, 0, 2, 75);
    idle_gap();
    // random runs
    for (int n = 0; n < 8; n++) begin
      rl = $urandom_range(40);
      rt = ($urandom_range(1) == 1) ? $urandom_range(30, 1) : 0;
      re = $urandom_range(30);
      if (rt == 0 && re == 0) re = 7;
      run_case(rl, rt, re, $urandom_range(90, 20));
      idle_gap();
    end

    // reset in the middle of a load
    load_len = (ADDR_W+1)'(4);
    timeout_lim = 32'd0;
    start_in = 1'b1;
    ld_valid = 1'b1;
    ld_data = $urandom;
    xbase = xfers;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (xfers - xbase >= 2) break;
      ld_data = $urandom;
    end
    chk("two_words_taken", xfers - xbase, 2);
    rst = 1'b1;
    start_in = 1'b0;
    tick();
    rst = 1'b0;
    chk("abort_imem_we", imem_we, 0);
    chk("abort_imem_sel", imem_sel, 0);
    chk("abort_ld_ready", ld_ready, 0);
    chk("abort_core_rst", core_rst, 1);
    chk("abort_busy", busy, 0);
    chk("abort_cycle_cnt", cycle_cnt, 0);
    wb = wr_q.size();
    nr = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (ld_ready !== 1'b0) nr++;
    end
    chk("abort_no_writes", wr_q.size() - wb, 0);
    chk("abort_ready_low", nr, 0);
    ld_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/core_run_sequencer.md
Name: core_run_sequencer

Overview:
Top-level run controller for the RV32I buffer-internal core.
- Takes a host start request and streams a program from the host buffer into instruction BRAM, owning the BRAM port while it does so.
- Holds the core in reset during the load, then releases it and counts run cycles.
- Ends the run on ecall (32'h00000073) or a cycle timeout, then drains the pipeline and reports done.

Parameters:
ADDR_W, 10, instruction BRAM word-address width
DATA_W, 32, instruction/data word width
DRAIN_CYC, 4, cycles core stays enabled after ecall decode to retire in-flight ops (>=1)
ECALL_CODE, 32'h00000073, instruction word that terminates a run

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
start_in  in  1  host run request, level; sampled only in IDLE
load_len  in  ADDR_W+1  program length in words, 0..2^ADDR_W; latched on start
timeout_lim  in  32  max RUN cycles; 0 = no timeout; latched on start
ld_valid  in  1  host program word valid
ld_data  in  DATA_W  host program word
ld_ready  out  1  sequencer accepts ld_data this cycle
imem_sel  out  1  BRAM port owner: 1 = loader, 0 = core
imem_we  out  1  BRAM write enable (loader)
imem_addr  out  ADDR_W  BRAM write address (loader)
imem_wdata  out  DATA_W  BRAM write data
core_rst  out  1  core reset, active-high
core_en  out  1  core clock-enable / run
core_instr  in  DATA_W  instruction in core decode stage
core_instr_vld  in  1  core_instr is a valid, non-bubble instruction
busy  out  1  high in every state except IDLE and DONE
done  out  1  high in DONE
timeout_err  out  1  run ended by timeout; valid while done=1
cycle_cnt  out  32  RUN+DRAIN cycle count; holds after done

Behaviour:
Reset values (rst=1 at a clock edge):
- state=IDLE; ld_ready=0, imem_we=0, imem_addr=0, imem_wdata=0.
- imem_sel=0, core_rst=1, core_en=0.
- busy=0, done=0, timeout_err=0, cycle_cnt=0.
- rst mid-operation aborts immediately: no further BRAM writes, core held in reset.

FSM states: IDLE, LOAD, RUN, DRAIN, DONE. All outputs are registered.
- IDLE:
  - core_rst=1, imem_sel=0.
  - On start_in=1: latch load_len and timeout_lim, clear cycle_cnt and timeout_err.
  - Go to LOAD if load_len!=0, else RUN.
- LOAD:
  - imem_sel=1, core_rst=1, ld_ready=1.
  - Handshake: a word transfers when ld_valid & ld_ready at the edge. The same edge drives imem_we=1, imem_wdata=ld_data and imem_addr=word index, so the BRAM write happens one cycle after acceptance.
  - The index increments per transfer. After the load_len-th transfer, deassert ld_ready next cycle.
  - Once the final write is issued, go to RUN. imem_sel drops to 0 only after the final imem_we cycle.
  - ld_valid low stalls without limit. Words offered outside LOAD are ignored (ld_ready=0).
- RUN:
  - core_rst=0, core_en=1, cycle_cnt += 1 per cycle (saturates at 32'hFFFFFFFF).
  - core_instr_vld & core_instr==ECALL_CODE: go to DRAIN, load drain counter with DRAIN_CYC-1.
  - timeout_lim!=0 and cycle_cnt==timeout_lim-1: go to DONE with timeout_err=1 and core_en=0 next cycle.
  - Ecall and timeout on the same cycle: ecall wins, timeout_err=0.
- DRAIN:
  - core_en stays 1, cycle_cnt keeps counting.
  - When the drain counter reaches 0: go to DONE. DRAIN_CYC cycles in DRAIN in total.
  - Timeout is not evaluated in DRAIN.
- DONE:
  - core_en=0, core_rst=0 (architectural state kept for host readback), done=1, busy=0.
  - Stay while start_in=1. When start_in=0, go to IDLE next cycle (done=0).
  - start_in held high in DONE never triggers a second run; a new run needs a low-high cycle via IDLE.

Width rules:
- The load index is ADDR_W+1 bits. load_len=2^ADDR_W writes addresses 0..2^ADDR_W-1 and imem_addr wraps nowhere.
- load_len is compared against the full index.

Decomposition:
- Shared package rv32_ctrl_pkg:
  - state enum {IDLE, LOAD, RUN, DRAIN, DONE};
  - ECALL_CODE = 32'h00000073 and EBREAK_CODE = 32'h00100073 constants for reuse by decode.
- One sub-module: imem_loader (LOAD handshake, write index, BRAM write port), with start/finish strobes to the FSM.
- The FSM, cycle counter, drain counter and timeout compare stay in core_run_sequencer.

Test Plan:
- Basic run: rst 2 cycles, load_len=4, words A0..A3 with ld_valid continuous, start_in=1; core_instr=ECALL_CODE on RUN cycle 10, DRAIN_CYC=4.
  -> imem_we at addr 0..3 with A0..A3; core_rst falls after the last write; done=1 with cycle_cnt=14 and timeout_err=0.
- Backpressure: load_len=3, ld_valid toggling 1,0,0,1,0,1.
  -> exactly 3 writes, addresses 0,1,2 in order, no writes during ld_valid=0; state then RUN.
- Timeout: timeout_lim=20, no ecall.
  -> done=1 with timeout_err=1, cycle_cnt=20, core_en=0 from the DONE cycle on.
- Ecall coinciding with the timeout cycle (timeout_lim=8, ecall on RUN cycle 8).
  -> DRAIN entered, timeout_err=0, cycle_cnt=8+DRAIN_CYC.
- Restart and empty load: after done, hold start_in=1 for 5 cycles -> no new run. Drop start_in, then raise it with load_len=0.
  -> LOAD skipped, no imem_we, RUN directly.
- Reset mid-LOAD after 2 of 4 words.
  -> next cycle imem_we=0, imem_sel=0, ld_ready=0, core_rst=1, state IDLE, cycle_cnt=0.
